// File: rtl/dtage_update_ctrl.sv
// Deferred TAGE update controller. Buffers resolved branches in a small queue
// and sequences the read-modify-write of the provider entry, then walks the
// higher tables looking for a free (u == 0) slot to allocate on a mispredict.
module dtage_update_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NTAB       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_valid,
    output logic        resolve_ready,
    input  logic [15:0] resolve_pc,
    input  logic [63:0] resolve_hist,
    input  logic        resolve_taken,
    input  logic        resolve_pred,
    input  logic [2:0]  resolve_prov,
    output logic        tbl_req,
    input  logic        tbl_gnt,
    output logic        tbl_we,
    output logic [1:0]  tbl_sel,
    output logic [7:0]  tbl_idx,
    output logic [15:0] tbl_wdata,
    input  logic [15:0] tbl_rdata,
    output logic        busy,
    output logic [7:0]  alloc_fail_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 85;

    typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StArd, StAwait, StAwr} state_e;

    function automatic logic [7:0] calc_idx(logic [15:0] pc, logic [63:0] hist, logic [1:0] t);
        logic [15:0] h;
        h = hist[{t, 4'b0000} +: 16];
        return pc[7:0] ^ h[7:0] ^ h[15:8];
    endfunction

    function automatic logic [10:0] calc_tag(logic [15:0] pc, logic [63:0] hist, logic [1:0] t);
        logic [15:0] h;
        h = hist[{t, 4'b0000} +: 16];
        return pc[15:5] ^ h[10:0];
    endfunction

    // Resolve queue
    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          fifo_full, fifo_empty, push, pop;
    logic [EW-1:0] head;

    assign fifo_empty    = (wptr_q == rptr_q);
    assign fifo_full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign resolve_ready = rst_n && !fifo_full;
    assign push          = resolve_valid && resolve_ready;
    assign head          = fifo_q[rptr_q[AW-1:0]];

    // Queue storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q[AW-1:0]] <= {resolve_pc, resolve_hist, resolve_taken, resolve_pred,
                                       resolve_prov};
        end
    end

    // Queue pointers advance independently so push and pop can coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    logic [15:0] head_pc;
    logic [63:0] head_hist;
    logic        head_taken, head_pred;
    logic [2:0]  head_prov, prov_m1;

    assign head_pc    = head[84:69];
    assign head_hist  = head[68:5];
    assign head_taken = head[4];
    assign head_pred  = head[3];
    assign head_prov  = head[2:0];
    assign prov_m1    = head_prov - 3'd1;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [63:0] hist_q, hist_d;
    logic        taken_q, taken_d, mispred_q, mispred_d, ok_q, ok_d;
    logic [1:0]  t_q, t_d, next_t;
    logic        t_last;
    logic        req_q, req_d, we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  idx_q, idx_d, fail_q, fail_d;
    logic [15:0] wdata_q, wdata_d;
    logic [2:0]  rd_ctr, ctr_upd;
    logic [1:0]  rd_u, u_upd;

    assign next_t = t_q + 2'd1;
    assign t_last = ({30'd0, t_q} >= NTAB - 1);
    assign rd_ctr = tbl_rdata[4:2];
    assign rd_u   = tbl_rdata[1:0];

    // Saturating counter updates for the provider entry
    always_comb begin
        ctr_upd = rd_ctr;
        u_upd   = rd_u;
        if (taken_q) begin
            if (rd_ctr != 3'd7) ctr_upd = rd_ctr + 3'd1;
        end else if (rd_ctr != 3'd0) begin
            ctr_upd = rd_ctr - 3'd1;
        end
        if (!mispred_q) begin
            if (rd_u != 2'd3) u_upd = rd_u + 2'd1;
        end else if (rd_u != 2'd0) begin
            u_upd = rd_u - 2'd1;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hist_d    = hist_q;
        taken_d   = taken_q;
        mispred_d = mispred_q;
        ok_d      = ok_q;
        t_d       = t_q;
        req_d     = req_q;
        we_d      = we_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        fail_d    = fail_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    pc_d      = head_pc;
                    hist_d    = head_hist;
                    taken_d   = head_taken;
                    mispred_d = (head_pred != head_taken);
                    if (head_prov != 3'd0 && {29'd0, head_prov} <= NTAB) begin
                        t_d     = prov_m1[1:0];
                        state_d = StRd;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = prov_m1[1:0];
                        idx_d   = calc_idx(head_pc, head_hist, prov_m1[1:0]);
                    end else if (head_prov == 3'd0 && head_pred != head_taken) begin
                        t_d     = 2'd0;
                        state_d = StArd;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = 2'd0;
                        idx_d   = calc_idx(head_pc, head_hist, 2'd0);
                    end
                end
            end
            StRd, StArd: begin
                if (tbl_gnt) begin
                    state_d = (state_q == StRd) ? StWait : StAwait;
                    req_d   = 1'b0;
                end
            end
            StWait: begin
                wdata_d = {tbl_rdata[15:5], ctr_upd, u_upd};
                req_d   = 1'b1;
                we_d    = 1'b1;
                state_d = StWr;
            end
            StAwait: begin
                // Free slot: claim it weakly biased toward the resolved direction.
                if (rd_u == 2'd0) begin
                    wdata_d = {calc_tag(pc_q, hist_q, t_q), taken_q ? 3'd4 : 3'd3, 2'd0};
                    ok_d    = 1'b1;
                end else begin
                    wdata_d = {tbl_rdata[15:2], rd_u - 2'd1};
                    ok_d    = 1'b0;
                end
                req_d   = 1'b1;
                we_d    = 1'b1;
                state_d = StAwr;
            end
            StWr, StAwr: begin
                if (tbl_gnt) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = StIdle;
                    if ((state_q == StWr) ? (mispred_q && !t_last) : (!ok_q && !t_last)) begin
                        t_d     = next_t;
                        state_d = StArd;
                        req_d   = 1'b1;
                        sel_d   = next_t;
                        idx_d   = calc_idx(pc_q, hist_q, next_t);
                    end else if (state_q == StAwr && !ok_q && fail_q != 8'hff) begin
                        fail_d = fail_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            hist_q    <= '0;
            taken_q   <= 1'b0;
            mispred_q <= 1'b0;
            ok_q      <= 1'b0;
            t_q       <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hist_q    <= hist_d;
            taken_q   <= taken_d;
            mispred_q <= mispred_d;
            ok_q      <= ok_d;
            t_q       <= t_d;
            req_q     <= req_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            fail_q    <= fail_d;
        end
    end

    assign tbl_req        = req_q;
    assign tbl_we         = we_q;
    assign tbl_sel        = sel_q;
    assign tbl_idx        = idx_q;
    assign tbl_wdata      = wdata_q;
    assign alloc_fail_cnt = fail_q;
    assign busy           = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_dtage_update_ctrl.sv
// Scoreboard bench: a table-level reference model predicts every table access
// per accepted update; a monitor pops and compares on each granted access.
module tb_dtage_update_ctrl;

    localparam int DEPTH = 4;
    localparam int NT    = 4;

    logic        clk, rst_n;
    logic        resolve_valid, resolve_ready;
    logic [15:0] resolve_pc;
    logic [63:0] resolve_hist;
    logic        resolve_taken, resolve_pred;
    logic [2:0]  resolve_prov;
    logic        tbl_req, tbl_gnt, tbl_we;
    logic [1:0]  tbl_sel;
    logic [7:0]  tbl_idx;
    logic [15:0] tbl_wdata, tbl_rdata;
    logic        busy;
    logic [7:0]  alloc_fail_cnt;

    dtage_update_ctrl #(.FIFO_DEPTH(DEPTH), .NTAB(NT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .resolve_valid  (resolve_valid),
        .resolve_ready  (resolve_ready),
        .resolve_pc     (resolve_pc),
        .resolve_hist   (resolve_hist),
        .resolve_taken  (resolve_taken),
        .resolve_pred   (resolve_pred),
        .resolve_prov   (resolve_prov),
        .tbl_req        (tbl_req),
        .tbl_gnt        (tbl_gnt),
        .tbl_we         (tbl_we),
        .tbl_sel        (tbl_sel),
        .tbl_idx        (tbl_idx),
        .tbl_wdata      (tbl_wdata),
        .tbl_rdata      (tbl_rdata),
        .busy           (busy),
        .alloc_fail_cnt (alloc_fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] tmem [NT][256];  // table contents seen by the DUT
    logic [15:0] rmem [NT][256];  // reference model's view of the tables
    logic [26:0] expq [$];        // {we, sel, idx, wdata}
    int nvec = 0, nfail = 0, ref_fail = 0, nwrites = 0, gnt_mode = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] idx_of(logic [15:0] pc, logic [63:0] hist, int t);
        logic [15:0] h;
        h = 16'(hist >> (16 * t));
        return pc[7:0] ^ h[7:0] ^ h[15:8];
    endfunction

    function automatic logic [10:0] tag_of(logic [15:0] pc, logic [63:0] hist, int t);
        logic [15:0] h;
        h = 16'(hist >> (16 * t));
        return pc[15:5] ^ h[10:0];
    endfunction

    function automatic void push_exp(bit we, int t, logic [7:0] i, logic [15:0] d);
        expq.push_back({we, 2'(t), i, d});
    endfunction

    // Reference: what the tables should see for one update, in order.
    function automatic void model_update(logic [15:0] pc, logic [63:0] hist, bit taken,
                                         bit pred, int prov);
        bit mis, alloc, done;
        int start, ctr, u;
        logic [7:0] i;
        logic [15:0] e;
        mis   = (pred != taken);
        alloc = 0;
        start = 0;
        if (prov >= 1 && prov <= NT) begin
            i = idx_of(pc, hist, prov - 1);
            e = rmem[prov-1][i];
            ctr = taken ? ((e[4:2] == 7) ? 7 : e[4:2] + 1) : ((e[4:2] == 0) ? 0 : e[4:2] - 1);
            u   = mis ? ((e[1:0] == 0) ? 0 : e[1:0] - 1) : ((e[1:0] == 3) ? 3 : e[1:0] + 1);
            push_exp(0, prov - 1, i, 16'h0);
            rmem[prov-1][i] = {e[15:5], 3'(ctr), 2'(u)};
            push_exp(1, prov - 1, i, rmem[prov-1][i]);
            alloc = mis;
            start = prov;
        end else if (prov == 0) begin
            alloc = mis;
        end
        if (alloc && start < NT) begin
            done = 0;
            for (int t = start; t < NT && !done; t++) begin
                i = idx_of(pc, hist, t);
                e = rmem[t][i];
                push_exp(0, t, i, 16'h0);
                if (e[1:0] == 0) begin
                    rmem[t][i] = {tag_of(pc, hist, t), taken ? 3'd4 : 3'd3, 2'd0};
                    done = 1;
                end else begin
                    rmem[t][i] = {e[15:2], e[1:0] - 2'd1};
                end
                push_exp(1, t, i, rmem[t][i]);
            end
            if (!done && ref_fail < 255) ref_fail++;
        end
    endfunction

    task automatic sync_tmem();
        for (int t = 0; t < NT; t++)
            for (int k = 0; k < 256; k++) tmem[t][k] = rmem[t][k];
    endtask

    // Called at posedge+2; returns at the next posedge+2.
    task automatic offer(input logic [15:0] pc, input logic [63:0] hist, input bit taken,
                         input bit pred, input int prov, output bit acc);
        bit rdy;
        resolve_valid = 1'b1;
        resolve_pc    = pc;
        resolve_hist  = hist;
        resolve_taken = taken;
        resolve_pred  = pred;
        resolve_prov  = 3'(prov);
        rdy = resolve_ready;
        @(posedge clk);
        acc = rdy;
        if (acc) model_update(pc, hist, taken, pred, prov);
        #2;
        resolve_valid = 1'b0;
    endtask

    task automatic offer_rand(output bit acc);
        offer(16'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
              $urandom_range(0, 4), acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 3000) check("drain_timeout", 1, 0);
    endtask

    // Grant generator
    initial begin
        tbl_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       tbl_gnt = ($urandom % 10) < 7;
                1:       tbl_gnt = 1'b1;
                2:       tbl_gnt = 1'b0;
                default: tbl_gnt = !tbl_we;
            endcase
        end
    end

    // Monitor and table responder
    initial begin
        logic [26:0] act, e;
        tbl_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && tbl_req && tbl_gnt) begin
                act = {tbl_we, tbl_sel, tbl_idx, tbl_wdata};
                if (expq.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_access: got %0h expected none", act);
                end else begin
                    e = expq.pop_front();
                    if (e[26]) check("tbl_write", act, e);
                    else check("tbl_read", act[26:16], e[26:16]);
                end
                if (tbl_we) begin
                    tmem[tbl_sel][tbl_idx] = tbl_wdata;
                    nwrites++;
                end else begin
                    tbl_rdata = tmem[tbl_sel][tbl_idx];
                end
            end
        end
    end

    initial begin
        bit acc;
        int k, wk, nacc, wr_before;
        logic [15:0] pc;
        logic [63:0] hist;
        logic [7:0] i;
        logic [26:0] e0;

        rst_n = 1'b0;
        resolve_valid = 1'b0;
        resolve_pc = '0;
        resolve_hist = '0;
        resolve_taken = 1'b0;
        resolve_pred = 1'b0;
        resolve_prov = '0;
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < 256; j++) rmem[t][j] = 16'($urandom);
        sync_tmem();
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", resolve_ready, 0);
        check("rst_req", tbl_req, 0);
        check("rst_we", tbl_we, 0);
        check("rst_sel", tbl_sel, 0);
        check("rst_idx", tbl_idx, 0);
        check("rst_wdata", tbl_wdata, 0);
        check("rst_cnt", alloc_fail_cnt, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("ready_after_rst", resolve_ready, 1);

        // Correct tagged update, latency with constant grant
        pc = 16'hbeef;
        hist = 64'h1234_5678_9abc_def0;
        i = idx_of(pc, hist, 1);
        rmem[1][i] = {11'h155, 3'd7, 2'd1};
        sync_tmem();
        offer(pc, hist, 1, 1, 2, acc);
        check("accept_022", acc, 1);
        wk = -1;
        for (k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3 && tbl_req && tbl_we && tbl_gnt && wk < 0) wk = k;
            if (k == 4) check("idle_after_4", busy, 0);
        end
        check("write_latency", wk, 3);
        @(posedge clk);
        #2;
        check("entry_022", tmem[1][i], {11'h155, 3'd7, 2'd2});

        // Base mispredict allocates into table 0
        pc = 16'h4321;
        hist = 64'hffee_ddcc_bbaa_9988;
        i = idx_of(pc, hist, 0);
        rmem[0][i] = {11'h7ff, 3'd2, 2'd0};
        sync_tmem();
        offer(pc, hist, 1, 0, 0, acc);
        drain();
        check("entry_023", tmem[0][i], {tag_of(pc, hist, 0), 3'd4, 2'd0});

        // Allocation exhaustion
        pc = 16'h0a5a;
        hist = 64'h0f0f_1111_2222_3333;
        for (int t = 0; t < NT; t++) rmem[t][idx_of(pc, hist, t)] = {11'h123, 3'd5, 2'd2};
        sync_tmem();
        offer(pc, hist, 0, 1, 0, acc);
        drain();
        check("fail_cnt_024", alloc_fail_cnt, 1);
        for (int t = 0; t < NT; t++)
            check("u_024", tmem[t][idx_of(pc, hist, t)], {11'h123, 3'd5, 2'd1});

        // Counter floor
        pc = 16'h7777;
        hist = 64'h0102_0304_0506_0708;
        i = idx_of(pc, hist, 2);
        rmem[2][i] = {11'h2aa, 3'd0, 2'd1};
        sync_tmem();
        offer(pc, hist, 0, 0, 3, acc);
        drain();
        check("ctr_floor", tmem[2][i], {11'h2aa, 3'd0, 2'd2});

        // Backpressure: one update in flight plus a full queue
        gnt_mode = 2;
        offer(16'h1357, 64'h2468_ace0_1357_9bdf, 1, 1, 1, acc);
        nacc = acc;
        e0 = expq[0];
        for (k = 0; k < 5; k++) begin
            offer_rand(acc);
            nacc += acc;
        end
        check("accepted_025", nacc, DEPTH + 1);
        check("ready_full", resolve_ready, 0);
        for (k = 0; k < 3; k++) begin
            check("hold_req", {tbl_req, tbl_we, tbl_sel, tbl_idx}, {2'b10, e0[25:16]});
            @(posedge clk);
            #2;
        end
        gnt_mode = 0;
        drain();

        // Random traffic
        for (k = 0; k < 200; k++) begin
            if ($urandom % 4 != 0) offer_rand(acc);
            else begin
                @(posedge clk);
                #2;
            end
        end
        drain();
        check("fail_cnt_rand", alloc_fail_cnt, ref_fail);

        // Reset while a write waits for grant
        gnt_mode = 3;
        offer(16'h2222, 64'h3333_4444_5555_6666, 1, 1, 2, acc);
        offer_rand(acc);
        offer_rand(acc);
        k = 0;
        while (!(tbl_req && tbl_we) && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("reached_wr", k < 50, 1);
        repeat (2) @(posedge clk);
        #2;
        wr_before = nwrites;
        rst_n = 1'b0;
        #1;
        check("req_in_rst", tbl_req, 0);
        check("ready_in_rst", resolve_ready, 0);
        expq.delete();
        for (int t = 0; t < NT; t++)
            for (int j = 0; j < 256; j++) rmem[t][j] = tmem[t][j];
        ref_fail = 0;
        gnt_mode = 1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("busy_after_rst", busy, 0);
        check("no_write_after_rst", nwrites, wr_before);

        // Failed-allocation counter saturates
        for (k = 0; k < 258; k++) begin
            for (int t = 0; t < NT; t++)
                for (int j = 0; j < 256; j++)
                    rmem[t][j] = {16'($urandom) & 16'hfffc} | 16'($urandom_range(1, 3));
            sync_tmem();
            offer(16'($urandom), {$urandom, $urandom}, 1, 0, 0, acc);
            drain();
        end
        check("fail_cnt_sat", alloc_fail_cnt, 255);
        check("fail_cnt_model", alloc_fail_cnt, ref_fail);
        check("queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
